// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel arbiter.
// Holds the arbiter state encoding, channel index type and priority rotation.
package dma_pkg;

  typedef logic [1:0] ch_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam logic [7:0] PRIO_RESET = 8'b11_10_01_00;

  // Served channel drops to slot 3; the rest close ranks in order.
  function automatic logic [7:0] prio_rotate(
    input logic [7:0] order,
    input ch_idx_t    ch
  );
    logic [7:0] r;
    logic [1:0] k;
    r = '0;
    k = '0;
    for (int i = 0; i < 4; i++) begin
      if (order[2*i +: 2] != ch) begin
        r[2*k +: 2] = order[2*i +: 2];
        k = k + 2'd1;
      end
    end
    r[7:6] = ch;
    return r;
  endfunction

  function automatic logic [3:0] ch_onehot(input ch_idx_t ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/dma_priority_select.sv
// Combinational winner pick: first channel in the priority list with a live
// request, scanning from slot 0 (highest) upward.
module dma_priority_select
  import dma_pkg::*;
(
  input  logic [3:0] reqVec,
  input  logic [7:0] priorityOrder,
  output ch_idx_t    winner,
  output logic       anyReq
);

  always_comb begin
    winner = '0;
    anyReq = |reqVec;
    for (int i = 3; i >= 0; i--) begin
      if (reqVec[priorityOrder[2*i +: 2]])
        winner = priorityOrder[2*i +: 2];
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter: request sensing, HRQ/HLDA handshake, fixed or
// rotating priority, and one-hot DACK for the life of a transfer.
module dma_priority_arbiter #(
  parameter int         NUM_CH     = 4,
  parameter logic [7:0] PRIO_RESET = dma_pkg::PRIO_RESET
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic              dreqSenseLow,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              controllerDisable,
  input  logic              HLDA,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [1:0]        grantChannel,
  output logic              grantValid,
  output logic [7:0]        priorityOrder
);

  import dma_pkg::*;

  arb_state_t  state;
  arb_state_t  state_nx;
  logic [3:0]  req_vec;
  ch_idx_t     sel_ch;
  logic        any_req;
  logic [7:0]  prio_nx;

  assign req_vec = (DREQ ^ {NUM_CH{dreqSenseLow}}) & ~maskReg;

  dma_priority_select u_sel (
    .reqVec        (req_vec),
    .priorityOrder (priorityOrder),
    .winner        (sel_ch),
    .anyReq        (any_req)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (any_req && !controllerDisable)
          state_nx = REQ;
      end
      REQ: begin
        if (HLDA)
          state_nx = any_req ? GRANT : RELEASE;
        else if (!any_req)
          state_nx = IDLE;
      end
      GRANT: begin
        if (transferDone)
          state_nx = RELEASE;
        else if (!HLDA)
          state_nx = IDLE;
      end
      RELEASE: begin
        if (!HLDA)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Order is frozen during a grant; fixed-mode reload waits for grant exit.
  always_comb begin
    prio_nx = priorityOrder;
    if (state == GRANT) begin
      if (state_nx == RELEASE && priorityType)
        prio_nx = prio_rotate(priorityOrder, grantChannel);
      else if (state_nx != GRANT && !priorityType)
        prio_nx = PRIO_RESET;
    end else if (!priorityType) begin
      prio_nx = PRIO_RESET;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= '0;
      grantChannel  <= '0;
      grantValid    <= 1'b0;
      priorityOrder <= PRIO_RESET;
    end else begin
      state         <= state_nx;
      HRQ           <= (state_nx == REQ) || (state_nx == GRANT);
      grantValid    <= (state_nx == GRANT);
      priorityOrder <= prio_nx;
      if (state == REQ && state_nx == GRANT) begin
        grantChannel <= sel_ch;
        DACK         <= ch_onehot(sel_ch);
      end else if (state_nx != GRANT) begin
        grantChannel <= '0;
        DACK         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter with an expected-value queue.
// Each step queues the expected output word, clocks, then pops and checks it.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic       dreqSenseLow;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       controllerDisable;
  logic       HLDA;
  logic       transferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] grantChannel;
  logic       grantValid;
  logic [7:0] priorityOrder;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  dma_priority_arbiter dut (
    .CLK               (CLK),
    .RESET_N           (RESET_N),
    .DREQ              (DREQ),
    .dreqSenseLow      (dreqSenseLow),
    .maskReg           (maskReg),
    .priorityType      (priorityType),
    .controllerDisable (controllerDisable),
    .HLDA              (HLDA),
    .transferDone      (transferDone),
    .HRQ               (HRQ),
    .DACK              (DACK),
    .grantChannel      (grantChannel),
    .grantValid        (grantValid),
    .priorityOrder     (priorityOrder)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] ev(
    input logic h, input logic g, input logic [1:0] c,
    input logic [3:0] d, input logic [7:0] p
  );
    return {h, g, c, d, p};
  endfunction

  task automatic compare_out();
    logic [15:0] e;
    logic [15:0] o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {HRQ, grantValid, grantChannel, DACK, priorityOrder};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed={hrq,gv,ch,dack,prio}=%h expected=%h", t, o, e);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge CLK);
    #1;
    compare_out();
  endtask

  task automatic now(input string tag, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare_out();
  endtask

  logic [7:0] po_seq [0:4];

  initial begin
    po_seq = '{8'hE4, 8'h39, 8'h4E, 8'h93, 8'hE4};
    RESET_N = 1'b0;
    DREQ = '0; dreqSenseLow = 0; maskReg = '0; priorityType = 0;
    controllerDisable = 0; HLDA = 0; transferDone = 0;
    repeat (2) @(posedge CLK);
    #1;
    now("reset", ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    @(negedge CLK);
    RESET_N = 1'b1;
    @(posedge CLK);
    #1;

    // fixed priority, HLDA two cycles after HRQ
    DREQ = 4'b0110;
    step("fix_req",   ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    step("fix_wait",  ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    HLDA = 1;
    step("fix_grant", ev(1, 1, 2'd1, 4'b0010, 8'hE4));
    step("fix_hold",  ev(1, 1, 2'd1, 4'b0010, 8'hE4));
    transferDone = 1;
    step("fix_done",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    transferDone = 0; HLDA = 0; DREQ = '0;
    step("fix_idle",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));

    // rotating priority, all channels requesting
    priorityType = 1;
    DREQ = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      HLDA = 1;
      step("rot_req",   ev(1, 0, 2'd0, 4'b0000, po_seq[i]));
      step("rot_grant", ev(1, 1, i[1:0], 4'b0001 << i, po_seq[i]));
      transferDone = 1;
      step("rot_done",  ev(0, 0, 2'd0, 4'b0000, po_seq[i+1]));
      transferDone = 0; HLDA = 0;
      step("rot_idle",  ev(0, 0, 2'd0, 4'b0000, po_seq[i+1]));
    end

    // serve ch2 alone, then switch to fixed while granted
    DREQ = 4'b0100; HLDA = 1;
    step("c2_req",    ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    step("c2_grant",  ev(1, 1, 2'd2, 4'b0100, 8'hE4));
    transferDone = 1;
    step("c2_done",   ev(0, 0, 2'd0, 4'b0000, 8'hB4));
    transferDone = 0; HLDA = 0;
    step("c2_idle",   ev(0, 0, 2'd0, 4'b0000, 8'hB4));
    HLDA = 1;
    step("rl_req",    ev(1, 0, 2'd0, 4'b0000, 8'hB4));
    step("rl_grant",  ev(1, 1, 2'd2, 4'b0100, 8'hB4));
    priorityType = 0;
    step("rl_defer",  ev(1, 1, 2'd2, 4'b0100, 8'hB4));
    transferDone = 1;
    step("rl_reload", ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    transferDone = 0; HLDA = 0;
    step("rl_idle",   ev(0, 0, 2'd0, 4'b0000, 8'hE4));

    // masking and sense inversion
    maskReg = 4'b0001; DREQ = 4'b0011; HLDA = 1;
    step("msk_req",   ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    step("msk_grant", ev(1, 1, 2'd1, 4'b0010, 8'hE4));
    DREQ = 4'b0001; maskReg = 4'b1111;
    step("msk_stable", ev(1, 1, 2'd1, 4'b0010, 8'hE4));
    transferDone = 1;
    step("msk_done",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    transferDone = 0; HLDA = 0;
    step("msk_idle",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    maskReg = 4'b0001; dreqSenseLow = 1; DREQ = 4'b1110;
    step("sense_no_hrq1", ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    step("sense_no_hrq2", ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    dreqSenseLow = 0; maskReg = '0; DREQ = '0;

    // withdrawal before HLDA
    DREQ = 4'b0001;
    step("wd_req",    ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    DREQ = '0;
    step("wd_idle",   ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    DREQ = 4'b0001;
    step("wd2_req",   ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    DREQ = '0; HLDA = 1;
    step("wd2_rel",   ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    HLDA = 0;
    step("wd2_idle",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));

    // abort by HLDA drop in rotating mode
    priorityType = 1; DREQ = 4'b0010;
    step("ab_req",    ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    HLDA = 1;
    step("ab_grant",  ev(1, 1, 2'd1, 4'b0010, 8'hE4));
    HLDA = 0;
    step("ab_abort",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));

    // done and HLDA drop together still rotate
    HLDA = 1;
    step("sim_req",   ev(1, 0, 2'd0, 4'b0000, 8'hE4));
    step("sim_grant", ev(1, 1, 2'd1, 4'b0010, 8'hE4));
    transferDone = 1; HLDA = 0;
    step("sim_rot",   ev(0, 0, 2'd0, 4'b0000, 8'h78));
    transferDone = 0;
    step("sim_idle",  ev(0, 0, 2'd0, 4'b0000, 8'h78));

    // disable blocks a new start but not a running cycle
    DREQ = 4'b0001; controllerDisable = 1;
    step("dis_block", ev(0, 0, 2'd0, 4'b0000, 8'h78));
    controllerDisable = 0;
    step("dis_req",   ev(1, 0, 2'd0, 4'b0000, 8'h78));
    controllerDisable = 1; HLDA = 1;
    step("dis_grant", ev(1, 1, 2'd0, 4'b0001, 8'h78));

    // asynchronous reset between edges while granted
    #3;
    RESET_N = 1'b0;
    #1;
    now("async_rst", ev(0, 0, 2'd0, 4'b0000, 8'hE4));
    DREQ = '0; HLDA = 0; controllerDisable = 0; priorityType = 0;
    @(negedge CLK);
    RESET_N = 1'b1;
    step("post_rst",  ev(0, 0, 2'd0, 4'b0000, 8'hE4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dma_priority_arbiter.md
# dma_priority_arbiter

Channel arbiter and bus-request sequencer for the 4-channel DMA controller. It samples the four DREQ lines against the mask register and runs the HRQ/HLDA hold handshake with the CPU. It selects one channel using fixed or rotating priority, and drives the one-hot DACK for the duration of a transfer. It sits between the external request/acknowledge pins and the timing-control state machine, and owns the priorityOrder register.

## Interface
- NUM_CH, 4, number of DMA channels; the design is fixed at 4, and the parameter exists for elaboration checks only.
- PRIO_RESET, 8'b11_10_01_00, reset priority order; field [1:0] is the highest-priority channel.
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- DREQ  in  4  per-channel DMA request; active high after sense adjust.
- dreqSenseLow  in  1  1 = DREQ pins are active low; inverted internally before use.
- maskReg  in  4  1 = channel masked, its request is ignored.
- priorityType  in  1  0 = fixed priority, 1 = rotating priority (commandReg.priorityType).
- controllerDisable  in  1  1 = no new arbitration starts.
- HLDA  in  1  hold acknowledge from the CPU.
- transferDone  in  1  one-cycle pulse from timing control at the end of a transfer (S4 exit or EOP).
- HRQ  out  1  hold request to the CPU.
- DACK  out  4  one-hot acknowledge to the granted channel; active high.
- grantChannel  out  2  index of the granted channel; valid while grantValid is 1.
- grantValid  out  1  1 while a channel owns the bus.
- priorityOrder  out  8  current order as four 2-bit channel indices, highest priority at [1:0].

## Operation
- Effective request: reqVec = (DREQ ^ {4{dreqSenseLow}}) & ~maskReg.
- The winner is the first channel in priorityOrder with its reqVec bit set.
- Fixed mode: priorityOrder stays at PRIO_RESET.
- State machine: IDLE, REQ, GRANT, RELEASE.
- IDLE -> REQ: on an edge with |reqVec and !controllerDisable.
- REQ -> GRANT: on an edge with HLDA=1 and |reqVec. The winner index is latched at this edge and does not change until the grant ends.
- REQ -> RELEASE: on an edge with HLDA=1 and reqVec=0, because the request was withdrawn. No DACK is issued.
- REQ -> IDLE: on an edge with HLDA=0 and reqVec=0. HRQ is withdrawn.
- GRANT -> RELEASE: on an edge with transferDone=1.
- GRANT -> IDLE: on an edge with HLDA=0 and transferDone=0. This is an abort: the grant is cleared and priority does not rotate.
- RELEASE -> IDLE: on an edge with HLDA=0.
- Rotation: when priorityType=1, GRANT -> RELEASE moves the served channel to the lowest slot ([7:6]). The other channels keep their relative order. Example: order 11_10_01_00 with channel 1 served becomes 01_11_10_00 as a list from [7:6] down to [1:0], so the new sequence is 00, 10, 11, 01.
- Changing priorityType from 1 to 0 reloads PRIO_RESET on the next edge, unless the block is in GRANT; in that case the reload happens at the edge where GRANT is left.
- controllerDisable set during REQ or GRANT does not abort; the current cycle completes.
- Mask or DREQ changes during GRANT have no effect on DACK.

## Timing
- Reset values (asynchronous, all outputs): HRQ=0, DACK=4'b0000, grantChannel=2'b00, grantValid=0, priorityOrder=PRIO_RESET, state=IDLE.
- All outputs are registered; there is no combinational path from input to output.
- HRQ=1 in REQ and GRANT. HRQ first goes high 1 cycle after the edge that samples a valid request.
- DACK and grantValid go high 1 cycle after the edge that samples HLDA=1 in REQ. Minimum latency from DREQ to DACK is 2 edges when HLDA is already high.
- DACK, grantValid and HRQ fall together 1 cycle after the edge that samples transferDone.
- The earliest new HRQ after RELEASE is 2 cycles after HLDA falls: one edge to reach IDLE, one edge to reach REQ.
- Simultaneous transferDone and HLDA=0 in GRANT: the block takes GRANT -> RELEASE, and priority rotates.
- Reset asserted mid-grant: all outputs clear immediately and asynchronously; no rotation is recorded.

## Structure
- Package dma_pkg holds:
  - the arb_state_t enum (IDLE, REQ, GRANT, RELEASE);
  - the PRIO_RESET constant;
  - the channel index typedef, logic [1:0].
- Sub-module dma_priority_select is combinational: inputs reqVec and priorityOrder, outputs winner index and anyReq. It is instantiated once.
- The rotation update function lives in dma_pkg.

## Test plan
- Fixed priority: DREQ=4'b0110, mask=0, HLDA raised 2 cycles after HRQ -> DACK=4'b0010 one cycle later; after a transferDone pulse, DACK=0 and HRQ=0.
- Rotating priority: DREQ=4'b1111 held, four grant/done cycles -> DACK sequence 0001, 0010, 0100, 1000, and priorityOrder returns to 8'b11_10_01_00.
- Masking and sense: maskReg=4'b0001, DREQ=4'b0011 -> DACK=4'b0010. Then dreqSenseLow=1 with DREQ=4'b1110 -> no HRQ, because channel 0 is masked.
- Withdrawal and abort:
  - DREQ drops before HLDA -> no DACK, and HRQ falls;
  - HLDA dropped in GRANT -> DACK=0 next cycle, priorityOrder unchanged.
- Asynchronous reset asserted in GRANT between clock edges -> HRQ=0, DACK=0, priorityOrder=8'b11_10_01_00 before the next edge.
